// File: rtl/fetch_controller_pkg.sv
// Shared defaults, FSM state type and helpers for the instruction fetch controller.
// Build flag FETCH_NOP_SKIP_EN (consumed by fetch_controller) drops all-zero words.
package fetch_controller_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-side holding register: one instruction word with its address and a valid bit.
// Priority: flush, then load, then consume; otherwise the contents stall in place.
module fetch_out_reg #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              consume,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= data_in;
      pc_reg    <= pc_in;
    end else if (consume) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_controller.sv
// Sequential instruction fetcher with valid/ready decode handshake, branch redirect and drain.
// Optional FETCH_NOP_SKIP_EN: all-zero instruction words are skipped instead of presented.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] EndAddress,
  output logic [ADDR_W-1:0] ImAddress,
  input  logic [DATA_W-1:0] ImReadData,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [DATA_W-1:0] InstrData,
  output logic [ADDR_W-1:0] InstrPc,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              Done,
  output logic [CNT_W-1:0]  FetchCount
);

  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              done_reg;

  logic active;
  logic handshake;
  logic slot_free;
  logic flush;
  logic capture;
  logic is_nop;
  logic load;
  logic at_end;

  assign active    = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign handshake = InstrValid && InstrReady;
  assign slot_free = !InstrValid || InstrReady;
  assign flush     = active && BranchTaken;
  // A redirect wins over both stall and capture in the same cycle.
  assign capture   = (state_reg == ST_FETCH) && !BranchTaken && slot_free;
  assign at_end    = (pc_reg == EndAddress);

`ifdef FETCH_NOP_SKIP_EN
  assign is_nop = (ImReadData == DATA_W'(NOP_WORD));
`else
  assign is_nop = 1'b0;
`endif

  assign load = capture && !is_nop;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (handshake) begin
        count_reg <= sat_inc(count_reg);
      end
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (BranchTaken) begin
            pc_reg <= BranchTarget;
          end else if (capture) begin
            pc_reg <= pc_reg + ADDR_W'(1);
            if (at_end) begin
              // A skipped final word leaves the output empty, so nothing is left to drain.
              if (is_nop) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (BranchTaken) begin
            state_reg <= ST_FETCH;
            pc_reg    <= BranchTarget;
          end else if (handshake) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  fetch_out_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load   (load),
    .flush  (flush),
    .consume(handshake),
    .data_in(ImReadData),
    .pc_in  (pc_reg),
    .valid  (InstrValid),
    .data   (InstrData),
    .pc     (InstrPc)
  );

  assign ImAddress  = pc_reg;
  assign Done       = done_reg;
  assign FetchCount = count_reg;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: ADDR_W, default 6, instruction memory address width (64 words).
REQ-002 Parameter: DATA_W, default 32, instruction word width.
REQ-003 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: Rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: Start  input  1  one-cycle pulse; begins fetching at address 0.
REQ-006 Port: EndAddress  input  ADDR_W  address of last instruction of the program.
REQ-007 Port: ImAddress  output  ADDR_W  read address to instruction memory; equals PC.
REQ-008 Port: ImReadData  input  DATA_W  combinational read data for ImAddress, valid in the same cycle.
REQ-009 Port: InstrValid  output  1  decode-side valid.
REQ-010 Port: InstrReady  input  1  decode-side ready.
REQ-011 Port: InstrData  output  DATA_W  held instruction word.
REQ-012 Port: InstrPc  output  ADDR_W  address of InstrData.
REQ-013 Port: BranchTaken  input  1  redirect pulse.
REQ-014 Port: BranchTarget  input  ADDR_W  redirect address.
REQ-015 Port: Done  output  1  program fully fetched and drained.
REQ-016 Port: FetchCount  output  16  count of instructions accepted by decode, saturating.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, DONE; PC is an ADDR_W register.
REQ-018 IDLE: Start -> FETCH, PC=0, FetchCount=0; no other transition.
REQ-019 FETCH: when output register empty or (InstrValid && InstrReady), capture ImReadData into InstrData, PC into InstrPc, set InstrValid, PC<=PC+1 modulo 2^ADDR_W.
REQ-020 FETCH: InstrValid && !InstrReady -> hold InstrData/InstrPc/PC unchanged (stall); InstrValid never drops without a handshake or flush.
REQ-021 Latency: first InstrValid asserted the cycle after the Start cycle (Start at edge N -> InstrValid at edge N+2 with InstrPc=0).
REQ-022 Capture of PC==EndAddress -> DRAIN; no further captures.
REQ-023 DRAIN: handshake on final word -> DONE; Done=1 in DONE, 0 elsewhere.
REQ-024 DONE: Start -> FETCH with PC=0, FetchCount=0.
REQ-025 BranchTaken in FETCH or DRAIN: clear InstrValid next cycle, PC<=BranchTarget, state<=FETCH; branch overrides stall and capture the same cycle.
REQ-026 A handshake coinciding with BranchTaken SHALL still increment FetchCount.
REQ-027 BranchTaken in IDLE or DONE ignored; Start outside IDLE/DONE ignored.
REQ-028 FetchCount increments on every InstrValid && InstrReady, saturating at 16'hFFFF.
REQ-029 PC wrap 63->0 permitted when EndAddress not yet reached; no error flagged.

Reset
REQ-030 Rst_n low at edge: state=IDLE, PC=0, InstrValid=0, InstrData=0, InstrPc=0, Done=0, FetchCount=0; overrides Start and BranchTaken, including mid-stall.
REQ-031 ImAddress SHALL read 0 during and after reset until first capture.

Configuration
REQ-032 Macro FETCH_NOP_SKIP_EN defined: ImReadData == 0 is not presented; PC advances, InstrValid unchanged, EndAddress check still applies (skipped last word -> DONE directly once output empty).
REQ-033 Macro undefined: all-zero words presented and counted like any other.

Structure
REQ-034 Shared package SHALL hold ADDR_W/DATA_W defaults, FSM state enum, NOP encoding constant 32'h0.
REQ-035 Single sub-module fetch_out_reg (valid/data/pc holding register with load/flush/stall).

Verification
REQ-036 Start, InstrReady=1, EndAddress=26 -> 27 words InstrPc 0..26 in consecutive cycles, Done=1, FetchCount=27.
REQ-037 InstrReady=0 for 5 cycles at InstrPc=4 -> InstrData/InstrPc/ImAddress stable, no loss; resumes at 5.
REQ-038 BranchTaken, BranchTarget=10 while InstrPc=6 -> InstrValid=0 one cycle, next InstrPc=10.
REQ-039 Rst_n=0 mid-stall at InstrPc=12 -> all outputs reset values next cycle, Start needed to resume at 0.
REQ-040 FETCH_NOP_SKIP_EN, zeros at 3,9,17,20 -> those PCs never presented, FetchCount=23 for EndAddress=26.
REQ-041 EndAddress=2, PC start via branch to 62 -> fetches 62,63,0,1,2 then DONE.
